// File: rtl/lock_code_sender_pkg.sv
// Shared definitions for the code sender and the lock it drives:
// state encoding, default timing parameters and the symbol-to-button mapping.
package lock_code_sender_pkg;

    localparam int DEF_CODE_LEN   = 5;
    localparam int DEF_TIMEOUT    = 8;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_MAX_TRIES  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_GAP,
        ST_FIN
    } state_e;

    // Returns {Button_1, Button_0} for one code symbol.
    function automatic logic [1:0] press(input logic sym);
        return {sym, ~sym};
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with an expiry flag; saturates at zero, so it never wraps.
module lock_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state registers always use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/lock_code_sender.sv
// Replays a stored code onto a two-button lock, waits for unlock, and retries
// after a timeout and an idle gap, up to MAX_TRIES attempts.
module lock_code_sender
    import lock_code_sender_pkg::*;
#(
    parameter int CODE_LEN   = DEF_CODE_LEN,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int MAX_TRIES  = DEF_MAX_TRIES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CODE_LEN-1:0]          code,
    input  logic                         abort,
    input  logic                         unlock,
    output logic                         Button_0,
    output logic                         Button_1,
    output logic                         busy,
    output logic                         done,
    output logic                         success,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries
);

    localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CODE_LEN - 1);
    localparam logic [TRY_W-1:0] MAX_T     = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);

    state_e              state_q;
    logic [CODE_LEN-1:0] shadow_q;
    logic [IDX_W-1:0]    idx_q;
    logic [TRY_W-1:0]    tries_q;
    logic                btn0_q, btn1_q, busy_q, done_q, success_q;

    logic                tmr_load, tmr_expired;
    logic [TMR_W-1:0]    tmr_val;

    // The timer is held loaded outside WAIT/GAP, so it arrives in WAIT already
    // at TIMEOUT-1; WAIT expiry reloads it with the gap length for GAP.
    assign tmr_load = !(state_q == ST_WAIT || state_q == ST_GAP) || tmr_expired;
    assign tmr_val  = (state_q == ST_WAIT) ? GAP_LOAD : WAIT_LOAD;

    lock_timer #(.WIDTH(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            idx_q     <= '0;
            tries_q   <= '0;
            btn0_q    <= 1'b0;
            btn1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            success_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != ST_IDLE && abort) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                btn0_q  <= 1'b0;
                btn1_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (start) begin
                        shadow_q             <= code;
                        tries_q              <= '0;
                        success_q            <= 1'b0;
                        idx_q                <= '0;
                        {btn1_q, btn0_q}     <= press(code[0]);
                        busy_q               <= 1'b1;
                        state_q              <= ST_SEND;
                    end
                    ST_SEND: if (idx_q == LAST_IDX) begin
                        tries_q          <= tries_q + ((tries_q != MAX_T) ? 1'b1 : 1'b0);
                        {btn1_q, btn0_q} <= 2'b00;
                        if (unlock) begin
                            success_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= ST_FIN;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else begin
                        idx_q            <= idx_q + 1'b1;
                        {btn1_q, btn0_q} <= press(shadow_q[idx_q + 1'b1]);
                    end
                    // Unlock outranks a simultaneous timeout.
                    ST_WAIT: if (unlock) begin
                        success_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= ST_FIN;
                    end else if (tmr_expired) begin
                        if (tries_q < MAX_T) begin
                            state_q <= ST_GAP;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end
                    end
                    ST_GAP: if (tmr_expired) begin
                        idx_q            <= '0;
                        {btn1_q, btn0_q} <= press(shadow_q[0]);
                        state_q          <= ST_SEND;
                    end
                    ST_FIN: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Button_0 = btn0_q;
    assign Button_1 = btn1_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign success  = success_q;
    assign tries    = tries_q;

endmodule
